// File: rtl/ncpu32k_dbus_ctrl.sv
// Data-bus controller: one outstanding load/store to a fixed-latency SRAM,
// one response beat per command through a one-entry buffer with optional bypass.
module ncpu32k_dbus_ctrl #(
    parameter int unsigned NCPU_AW       = 32,
    parameter int unsigned NCPU_DW       = 32,
    parameter int unsigned MEM_LATENCY   = 2,
    parameter int unsigned ENABLE_BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   dbus_cmd_valid,
    output logic                   dbus_cmd_ready,
    input  logic [NCPU_AW-1:0]     dbus_cmd_addr,
    input  logic [NCPU_DW/8-1:0]   dbus_cmd_we_msk,
    input  logic [NCPU_DW-1:0]     dbus_din,
    output logic                   dbus_valid,
    input  logic                   dbus_ready,
    output logic [NCPU_DW-1:0]     dbus_dout,
    input  logic                   dbus_cmd_flush,
    output logic                   mem_en,
    output logic [NCPU_DW/8-1:0]   mem_we,
    output logic [NCPU_AW-3:0]     mem_addr,
    output logic [NCPU_DW-1:0]     mem_din,
    input  logic [NCPU_DW-1:0]     mem_dout
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NCPU_DW-1:0]   buf_q, buf_d;
    logic                 is_store_q, is_store_d;
    logic                 hds_cmd;
    logic [NCPU_DW-1:0]   cap_data;
    logic                 unused_addr;

    assign unused_addr = ^dbus_cmd_addr[1:0];

    assign dbus_cmd_ready = (state_q == StIdle) & ~dbus_cmd_flush;
    assign hds_cmd        = dbus_cmd_valid & dbus_cmd_ready;

    assign mem_en   = hds_cmd;
    assign mem_we   = dbus_cmd_we_msk & {(NCPU_DW/8){hds_cmd}};
    assign mem_addr = dbus_cmd_addr[NCPU_AW-1:2];
    assign mem_din  = dbus_din;

    // Stores still return a beat, always with zero data.
    assign cap_data = is_store_q ? '0 : mem_dout;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        is_store_d = is_store_q;
        dbus_valid = 1'b0;
        dbus_dout  = buf_q;

        case (state_q)
            StIdle: begin
                if (hds_cmd) begin
                    cnt_d      = 4'(MEM_LATENCY - 1);
                    is_store_d = |dbus_cmd_we_msk;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (dbus_cmd_flush) begin
                    state_d = StIdle;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    buf_d = cap_data;
                    if (ENABLE_BYPASS != 0) begin
                        dbus_valid = 1'b1;
                        dbus_dout  = cap_data;
                        state_d    = dbus_ready ? StIdle : StResp;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                // Flush wins over a coincident response handshake.
                if (dbus_cmd_flush) begin
                    state_d = StIdle;
                end else begin
                    dbus_valid = 1'b1;
                    if (dbus_ready) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            buf_q      <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            is_store_q <= is_store_d;
        end
    end

`ifndef SYNTHESIS
    cmd_valid_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (dbus_cmd_valid && !dbus_cmd_ready && !dbus_cmd_flush) |=> dbus_cmd_valid)
    else $error("dbus_cmd_valid dropped before dbus_cmd_ready");
`endif

endmodule
